// File: rtl/s4ga_pkg.sv
// Shared S4GA sizing: default LUT count, LUT width and segment width,
// plus the derived segment and config-word sizes used by s4ga and s4ga_cfg_tx.
package s4ga_pkg;

  localparam int N_DEF    = 32;
  localparam int K_DEF    = 4;
  localparam int SI_W_DEF = 4;

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  // Segments per LUT config word for an arbitrary (n, k, si_w) geometry.
  function automatic int cfg_segs(input int n, input int k, input int si_w);
    return k * ceil_div($clog2(n), si_w) + ceil_div(2 ** k, si_w);
  endfunction

  localparam int IDX_W     = $clog2(N_DEF);
  localparam int IDX_SEGS  = ceil_div(IDX_W, SI_W_DEF);
  localparam int MASK_W    = 2 ** K_DEF;
  localparam int MASK_SEGS = ceil_div(MASK_W, SI_W_DEF);
  localparam int SEGS      = K_DEF * IDX_SEGS + MASK_SEGS;
  localparam int CFG_W     = SEGS * SI_W_DEF;

endpackage

// File: rtl/s4ga_cfg_ram.sv
// LUT config store: one write port and one registered read port.
// A read and a write to the same address on one edge return the old word.
module s4ga_cfg_ram
  import s4ga_pkg::*;
#(
  parameter int DEPTH = N_DEF,
  parameter int WIDTH = CFG_W,
  parameter int AW    = IDX_W
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [WIDTH-1:0] rd_data_r;

  // Storage is deliberately not reset; read samples the array before this edge's write lands.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[wr_addr] <= wr_data;
    end
    rd_data_r <= mem_r[rd_addr];
  end

  assign rd_data = rd_data_r;

endmodule

// File: rtl/s4ga_cfg_tx.sv
// S4GA config transmitter: streams every stored LUT config word, MSB segment
// first, one segment per clock, into the receiver's si pin while run is held.
module s4ga_cfg_tx
  import s4ga_pkg::*;
#(
  parameter int N    = N_DEF,
  parameter int K    = K_DEF,
  parameter int SI_W = SI_W_DEF
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                cfg_we,
  input  logic [$clog2(N)-1:0]                cfg_addr,
  input  logic [cfg_segs(N, K, SI_W)*SI_W-1:0] cfg_wdata,
  input  logic                                run,
  output logic [SI_W-1:0]                     so,
  output logic                                so_rst,
  output logic                                busy,
  output logic                                pass_done,
  output logic [$clog2(N)-1:0]                lut_idx
);

  localparam int AW     = $clog2(N);
  localparam int NSEG   = cfg_segs(N, K, SI_W);
  localparam int WORD_W = NSEG * SI_W;
  localparam int SEG_W  = (NSEG > 1) ? $clog2(NSEG) : 1;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam logic [AW-1:0]    LAST_LUT = AW'(N - 1);
  localparam logic [SEG_W-1:0] LAST_SEG = SEG_W'(NSEG - 1);

  logic [0:0]        state_r, state_s;
  logic [SEG_W-1:0]  seg_r, seg_s;
  logic [AW-1:0]     lut_r, lut_s, lut_inc_s, rd_addr_s;
  logic [WORD_W-1:0] shift_r, shift_s, rd_data_s;
  logic              so_rst_r, busy_r, pass_done_r;

  s4ga_cfg_ram #(
    .DEPTH (N),
    .WIDTH (WORD_W),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .we      (cfg_we),
    .wr_addr (cfg_addr),
    .wr_data (cfg_wdata),
    .rd_addr (rd_addr_s),
    .rd_data (rd_data_s)
  );

  // Next-state, counters and shift register; each new LUT loads the word prefetched last cycle.
  always_comb begin
    state_s   = state_r;
    seg_s     = seg_r;
    lut_s     = lut_r;
    shift_s   = shift_r;
    lut_inc_s = (lut_r == LAST_LUT) ? '0 : lut_r + AW'(1);
    case (state_r)
      ST_IDLE: begin
        seg_s = '0;
        lut_s = '0;
        if (run) begin
          state_s = ST_RUN;
          shift_s = rd_data_s;
        end else begin
          shift_s = '0;
        end
      end
      ST_RUN: begin
        if (seg_r == LAST_SEG) begin
          seg_s = '0;
          if ((lut_r == LAST_LUT) && !run) begin
            state_s = ST_IDLE;
            lut_s   = '0;
            shift_s = '0;
          end else begin
            lut_s   = lut_inc_s;
            shift_s = rd_data_s;
          end
        end else begin
          seg_s   = seg_r + SEG_W'(1);
          shift_s = {shift_r[WORD_W-SI_W-1:0], {SI_W{1'b0}}};
        end
      end
      default: begin
        state_s = ST_IDLE;
        seg_s   = '0;
        lut_s   = '0;
        shift_s = '0;
      end
    endcase
  end

  // Prefetch address: LUT 0 whenever a pass can start next, otherwise the following LUT.
  always_comb begin
    if (rst || (state_r != ST_RUN)) begin
      rd_addr_s = '0;
    end else begin
      rd_addr_s = lut_inc_s;
    end
  end

  // State and output flops; outputs are precomputed from next-state so they come straight off flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      seg_r       <= '0;
      lut_r       <= '0;
      shift_r     <= '0;
      so_rst_r    <= 1'b1;
      busy_r      <= 1'b0;
      pass_done_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      seg_r       <= seg_s;
      lut_r       <= lut_s;
      shift_r     <= shift_s;
      so_rst_r    <= (state_s == ST_IDLE);
      busy_r      <= (state_s == ST_RUN);
      pass_done_r <= (state_s == ST_RUN) && (seg_s == LAST_SEG) && (lut_s == LAST_LUT);
    end
  end

  assign so        = shift_r[WORD_W-1 -: SI_W];
  assign so_rst    = so_rst_r;
  assign busy      = busy_r;
  assign pass_done = pass_done_r;
  assign lut_idx   = lut_r;

endmodule

// File: tb/tb_s4ga_cfg_tx.sv
// Self-checking bench for s4ga_cfg_tx: directed scenarios plus randomized
// traffic, checked against a pass-position reference model.
module tb_s4ga_cfg_tx;

  localparam int TN    = 32;
  localparam int TSEGS = 12;
  localparam int TPASS = TN * TSEGS;

  logic        clk;
  logic        rst;
  logic        cfg_we;
  logic [4:0]  cfg_addr;
  logic [47:0] cfg_wdata;
  logic        run;
  logic [3:0]  so;
  logic        so_rst;
  logic        busy;
  logic        pass_done;
  logic [4:0]  lut_idx;

  int checks = 0;
  int errors = 0;

  // Reference model: whether a pass is running, position within the pass,
  // word of the LUT on the wire, word fetched for the next LUT start, store copy.
  bit          m_run = 1'b0;
  int          m_pos = 0;
  logic [47:0] m_word = 48'h0;
  logic [47:0] m_fetch = 48'h0;
  logic [47:0] m_mem [TN];

  s4ga_cfg_tx dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata),
    .run       (run),
    .so        (so),
    .so_rst    (so_rst),
    .busy      (busy),
    .pass_done (pass_done),
    .lut_idx   (lut_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // The next LUT's word is captured one edge before it starts; a write on that edge is not seen.
  task automatic model_edge(input bit r, input bit rn, input bit we, input int a, input logic [47:0] d);
    int          fa;
    logic [47:0] nf;
    fa = (r || !m_run) ? 0 : ((m_pos / TSEGS) + 1) % TN;
    nf = m_mem[fa];
    if (r) begin
      m_run = 1'b0;
      m_pos = 0;
    end else if (!m_run) begin
      if (rn) begin
        m_run  = 1'b1;
        m_pos  = 0;
        m_word = m_fetch;
      end
    end else if ((m_pos % TSEGS) == TSEGS - 1) begin
      if ((m_pos == TPASS - 1) && !rn) begin
        m_run = 1'b0;
        m_pos = 0;
      end else begin
        m_pos  = (m_pos + 1) % TPASS;
        m_word = m_fetch;
      end
    end else begin
      m_pos++;
    end
    m_fetch = nf;
    if (we) m_mem[a] = d;
  endtask

  task automatic check_all();
    logic [47:0] tmp;
    logic [3:0]  exp_so;
    tmp    = m_word >> ((TSEGS - 1 - (m_pos % TSEGS)) * 4);
    exp_so = m_run ? tmp[3:0] : 4'h0;
    check_eq("so", so, exp_so);
    check_eq("so_rst", so_rst, !m_run);
    check_eq("busy", busy, m_run);
    check_eq("pass_done", pass_done, m_run && (m_pos == TPASS - 1));
    check_eq("lut_idx", lut_idx, m_run ? (m_pos / TSEGS) : 0);
  endtask

  task automatic do_cycle(input bit r, input bit rn, input bit we, input int a, input logic [47:0] d);
    rst       = r;
    run       = rn;
    cfg_we    = we;
    cfg_addr  = a[4:0];
    cfg_wdata = d;
    @(posedge clk);
    model_edge(r, rn, we, a, d);
    @(negedge clk);
    check_all();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [63:0] r64;
    logic [47:0] d;
    bit          run_lvl;
    int          c;

    for (int i = 0; i < TN; i++) m_mem[i] = 48'h0;
    rst = 1'b1; run = 1'b0; cfg_we = 1'b0; cfg_addr = 5'd0; cfg_wdata = 48'h0;
    @(negedge clk);

    // Reset held for three cycles with run low.
    for (int i = 0; i < 3; i++) begin
      do_cycle(1'b1, 1'b0, 1'b0, 0, 48'h0);
      check_eq("rst_so_rst", so_rst, 1'b1);
      check_eq("rst_so", so, 4'h0);
      check_eq("rst_busy", busy, 1'b0);
    end

    // Fill the store while idle.
    for (int i = 0; i < TN; i++) begin
      r64 = {$urandom(), $urandom()};
      d   = (i == 0) ? 48'h123456789ABC : r64[47:0];
      do_cycle(1'b0, 1'b0, 1'b1, i, d);
    end
    for (int i = 0; i < 3; i++) do_cycle(1'b0, 1'b0, 1'b0, 0, 48'h0);

    // Three passes: order, hazard write to LUT 0 at t+5, run dropped at t+868.
    for (int k = 0; k <= 1160; k++) begin
      do_cycle(1'b0, k < 868, k == 5, 0, 48'h0);
      c = k + 1;
      if (c <= TSEGS) check_eq("order", so, c);
      if (c == 13) check_eq("lut_idx_t13", lut_idx, 5'd1);
      if ((c % TPASS) == 0) check_eq("pd_period", pass_done, 1'b1);
      if ((c >= TPASS + 1) && (c <= TPASS + TSEGS)) check_eq("hazard_zero", so, 4'h0);
      if (c == 1153) begin
        check_eq("stop_so_rst", so_rst, 1'b1);
        check_eq("stop_busy", busy, 1'b0);
      end
    end

    // Reset mid-pass with run held high, then restart.
    for (int k = 0; k < 200; k++) begin
      do_cycle(k == 150, 1'b1, 1'b0, 0, 48'h0);
      if (k == 150) begin
        check_eq("midrst_so_rst", so_rst, 1'b1);
        check_eq("midrst_lut", lut_idx, 5'd0);
        check_eq("midrst_pd", pass_done, 1'b0);
      end
    end

    // Randomized traffic: slow-toggling run, frequent writes, rare resets.
    run_lvl = 1'b1;
    for (int k = 0; k < 2500; k++) begin
      if ($urandom_range(0, 149) == 0) run_lvl = !run_lvl;
      r64 = {$urandom(), $urandom()};
      do_cycle($urandom_range(0, 599) == 0, run_lvl, $urandom_range(0, 2) == 0,
               $urandom_range(0, TN - 1), r64[47:0]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/s4ga_cfg_tx.md
S4GA_CFG_TX -- requirements
Module: s4ga_cfg_tx

Interface
REQ-001 Parameter N, default 32: number of LUTs streamed per pass.
REQ-002 Parameter K, default 4: number of inputs per LUT.
REQ-003 Parameter SI_W, default 4: width of one output segment.
REQ-004 Derived constants: IDX_W = clog2(N); IDX_SEGS = ceil(IDX_W/SI_W); MASK_W = 2**K; MASK_SEGS = ceil(MASK_W/SI_W); SEGS = K*IDX_SEGS + MASK_SEGS; CFG_W = SEGS*SI_W. Defaults give 5, 2, 16, 4, 12 and 48.
REQ-005 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-006 Port rst, input, 1: synchronous, active-high reset.
REQ-007 Port cfg_we, input, 1: configuration write strobe.
REQ-008 Port cfg_addr, input, clog2(N): index of the LUT being written.
REQ-009 Port cfg_wdata, input, CFG_W: LUT config word. Fields from MSB down: input[0] .. input[K-1], each zero-padded to IDX_SEGS*SI_W bits, then mask zero-padded to MASK_SEGS*SI_W bits.
REQ-010 Port run, input, 1: level request to stream.
REQ-011 Port so, output, SI_W: segment stream to the S4GA receiver si pin.
REQ-012 Port so_rst, output, 1: reset to the receiver.
REQ-013 Port busy, output, 1: high while in RUN.
REQ-014 Port pass_done, output, 1: one-cycle pulse on the last segment of LUT N-1.
REQ-015 Port lut_idx, output, clog2(N): index of the LUT currently being emitted.

Function
REQ-016 The FSM has two states, IDLE and RUN.
REQ-017 In IDLE: so_rst=1, so=0, busy=0, pass_done=0, lut_idx=0, segment counter=0.
REQ-018 IDLE with run=1 sampled at edge t: RUN from t+1. At cycle t+1: so_rst=0 and so = cfg[0][CFG_W-1 -: SI_W].
REQ-019 In RUN, exactly one segment is emitted every clock, with no backpressure and no gap cycles, including across LUT and pass boundaries.
REQ-020 Within a LUT, segments are emitted MSB-first. Order: input[0] segments, then input[1] .. input[K-1], then mask segments. This is a fixed SEGS cycles per LUT.
REQ-021 The LUT config is loaded into an output shift register at LUT start and shifted left SI_W bits per cycle. so is the top SI_W bits of that register, driven directly from a flop.
REQ-022 On the last segment, the shift register loads cfg[lut_idx+1], or cfg[0] when lut_idx=N-1 (wrap). lut_idx advances on the same edge.
REQ-023 pass_done=1 exactly during the cycle that emits the final mask segment of LUT N-1.
REQ-024 If run=0 during RUN, the current pass completes. The block returns to IDLE on the edge after pass_done; so_rst=1 in the following cycle. run re-asserting before that edge cancels the stop.
REQ-025 A pass is N*SEGS cycles (384 at defaults). Counters wrap with no overflow.
REQ-026 cfg writes are accepted in any state, one per cycle.
REQ-027 A write to the LUT currently being emitted does not affect the in-flight LUT; it takes effect on the next pass.
REQ-028 A write coincident with the fetch of the same address: the fetch returns the old data.
REQ-029 Padding bits in cfg_wdata are transmitted as written. The receiver discards them; the transmitter does not mask them.

Reset
REQ-030 rst=1 at any edge, including mid-LUT or mid-pass, forces IDLE, lut_idx=0, segment counter=0, shift register=0, so_rst=1 and pass_done=0 on the next cycle, overriding run.
REQ-031 The config store is not cleared by rst; its contents are undefined until written.

Structure
REQ-032 N, K, SI_W defaults and the derived constants IDX_SEGS, MASK_SEGS, SEGS and CFG_W live in the shared package s4ga_pkg, used by both s4ga and s4ga_cfg_tx.
REQ-033 Config storage is the sub-module s4ga_cfg_ram: N x CFG_W, one write port, one synchronous-style read port with read-before-write semantics. The FSM, counters and shift register remain in s4ga_cfg_tx.

Verification
REQ-034 Reset then idle: rst held 3 cycles, run=0 -> so_rst=1, so=0, busy=0 every cycle.
REQ-035 Segment order: cfg[0]=48'h123456789ABC, run=1 at t -> so = 1,2,3,4,5,6,7,8,9,A,B,C on cycles t+1..t+12; lut_idx=1 at t+13.
REQ-036 Pass timing: run held high -> pass_done pulses every 384 cycles, first at t+384; so is continuous across the wrap back to cfg[0].
REQ-037 Stop mid-pass: run dropped at cycle t+100 -> streaming continues to pass_done at t+384; so_rst=1 and busy=0 from t+385.
REQ-038 Write hazard: write cfg[0]=0 at t+5 while LUT 0 streams -> pass 1 still emits 6..C; pass 2 emits twelve zero segments for LUT 0.
REQ-039 Loopback into s4ga(N=32,K=4,SI_W=4) with so_rst to rst and so to si; LUT31 mask 16'hFFFF, all other configs 0 -> after the first pass_done, s4ga io_out[0]=1 and io_out[7:1]=0; rst asserted mid-pass -> both blocks resynchronise and the result repeats.
